// File: rtl/pipe_trace_pkg.sv
// Shared state encodings and entry-width helper for the pipeline trace buffer.
// PIPE_TRACE_TS_EN (define) adds a TS_W-bit timestamp to every stored entry.
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

`ifdef PIPE_TRACE_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    function automatic int entry_w(input int n_ch, input int ch_w, input int ts_w, input bit ts_en);
        return n_ch * ch_w + (ts_en ? ts_w : 0);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one read port with registered output.
// The read register only advances on rd_en, so the last read word holds while stalled.
module trace_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          iw_clk,
    input  logic          iw_rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge iw_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pipe_trace.sv
// Triggered pipeline trace: circular pre-trigger capture, post-trigger count, oldest-first readout.
// PIPE_TRACE_TS_EN (define) stores a free-running cycle timestamp in the top TS_W bits of each entry.
//
// state | meaning
// IDLE  | no capture, waiting for arm
// ARMED | writing every valid sample into the ring, watching for trigger
// POST  | trigger seen, writing the remaining post-trigger samples
// DONE  | trace frozen, streaming entries out oldest first
module pipe_trace
    import pipe_trace_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CH_W  = 24,
    parameter int DEPTH = 64,
    parameter int TS_W  = 16
) (
    input  logic                                         iw_clk,
    input  logic                                         iw_rst_n,
    input  logic [N_CH*CH_W-1:0]                         iw_ch,
    input  logic                                         iw_valid,
    input  logic                                         iw_arm,
    input  logic                                         iw_trig,
    input  logic [$clog2(DEPTH)-1:0]                     iw_post,
    input  logic                                         iw_rd_ready,
    output logic                                         ow_rd_valid,
    output logic [entry_w(N_CH, CH_W, TS_W, TS_EN)-1:0]  ow_rd_data,
    output logic [1:0]                                   ow_state,
    output logic [$clog2(DEPTH)-1:0]                     ow_trig_idx,
    output logic [$clog2(DEPTH):0]                       ow_fill
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = entry_w(N_CH, CH_W, TS_W, TS_EN);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_e state_q, state_d;

    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      post_cnt_q;
    logic [AW-1:0]      trig_slot_q;
    logic [AW:0]        fill_q;
    logic [AW:0]        issue_cnt_q;
    logic [AW:0]        xfer_cnt_q;
    logic               rd_valid_q;

    logic               wr_en;
    logic               trig_hit;
    logic               post_last;
    logic               rd_en;
    logic               xfer;
    logic               last_xfer;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] wr_data;

`ifdef PIPE_TRACE_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wr_data = {ts_q, iw_ch};
`else
    assign wr_data = iw_ch;
`endif

    // Arm takes priority over everything in its cycle, including a coincident sample.
    assign wr_en     = !iw_arm && iw_valid && (state_q == ST_ARMED || state_q == ST_POST);
    assign trig_hit  = !iw_arm && iw_valid && iw_trig && (state_q == ST_ARMED);
    assign post_last = (state_q == ST_POST) && wr_en && (post_cnt_q == AW'(1));

    assign oldest    = (fill_q == FULL) ? wr_ptr_q : '0;
    assign rd_addr   = oldest + issue_cnt_q[AW-1:0];
    assign rd_en     = (state_q == ST_DONE) && !iw_arm && (issue_cnt_q != fill_q)
                       && (!rd_valid_q || iw_rd_ready);
    assign xfer      = rd_valid_q && iw_rd_ready;
    assign last_xfer = xfer && (xfer_cnt_q == fill_q - 1'b1);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (iw_arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: if (trig_hit) state_d = (post_cnt_q == '0) ? ST_DONE : ST_POST;
                ST_POST:  if (post_last) state_d = ST_DONE;
                ST_DONE:  if (last_xfer) state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            wr_ptr_q    <= '0;
            post_cnt_q  <= '0;
            trig_slot_q <= '0;
            fill_q      <= '0;
            issue_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            rd_valid_q  <= 1'b0;
        end else if (iw_arm) begin
            wr_ptr_q    <= '0;
            post_cnt_q  <= iw_post;
            fill_q      <= '0;
            issue_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q != FULL) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            if (trig_hit) begin
                trig_slot_q <= wr_ptr_q;
            end
            if ((state_q == ST_POST) && wr_en) begin
                post_cnt_q <= post_cnt_q - 1'b1;
            end
            if (state_q != ST_DONE) begin
                issue_cnt_q <= '0;
                xfer_cnt_q  <= '0;
            end else begin
                if (rd_en) issue_cnt_q <= issue_cnt_q + 1'b1;
                if (xfer)  xfer_cnt_q  <= xfer_cnt_q + 1'b1;
            end
            if (last_xfer) begin
                rd_valid_q <= 1'b0;
            end else if (rd_en) begin
                rd_valid_q <= 1'b1;
            end else if (xfer) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    trace_ram #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr_q),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (ow_rd_data)
    );

    assign ow_rd_valid = rd_valid_q;
    assign ow_state    = state_q;
    assign ow_fill     = fill_q;
    assign ow_trig_idx = trig_slot_q - oldest;

endmodule

// File: tb/tb_pipe_trace.sv
// Scoreboard bench for pipe_trace (N_CH=2, CH_W=8, DEPTH=8): directed captures, stalls, aborts.
// Expected entries are queued by the stimulus; a negedge monitor checks every presented entry.
module tb_pipe_trace;
    import pipe_trace_pkg::*;

    localparam int N_CH  = 2;
    localparam int CH_W  = 8;
    localparam int DEPTH = 8;
    localparam int TS_W  = 4;
    localparam int AW    = 3;
    localparam int EW    = entry_w(N_CH, CH_W, TS_W, TS_EN);

    logic              iw_clk = 1'b0;
    logic              iw_rst_n = 1'b0;
    logic [15:0]       iw_ch = '0;
    logic              iw_valid = 1'b0;
    logic              iw_arm = 1'b0;
    logic              iw_trig = 1'b0;
    logic [AW-1:0]     iw_post = '0;
    logic              iw_rd_ready = 1'b1;
    logic              ow_rd_valid;
    logic [EW-1:0]     ow_rd_data;
    logic [1:0]        ow_state;
    logic [AW-1:0]     ow_trig_idx;
    logic [AW:0]       ow_fill;

    int checks = 0;
    int errors = 0;
    logic [15:0]     exp_q[$];
    logic [TS_W-1:0] ts_seen[$];

    pipe_trace #(.N_CH(N_CH), .CH_W(CH_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .iw_clk      (iw_clk),
        .iw_rst_n    (iw_rst_n),
        .iw_ch       (iw_ch),
        .iw_valid    (iw_valid),
        .iw_arm      (iw_arm),
        .iw_trig     (iw_trig),
        .iw_post     (iw_post),
        .iw_rd_ready (iw_rd_ready),
        .ow_rd_valid (ow_rd_valid),
        .ow_rd_data  (ow_rd_data),
        .ow_state    (ow_state),
        .ow_trig_idx (ow_trig_idx),
        .ow_fill     (ow_fill)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented entry must match the queue head; it is consumed only on transfer.
    always @(negedge iw_clk) begin
        if (iw_rst_n && ow_rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h required=none", ow_rd_data[15:0]);
            end else begin
                check("rd_data", 32'(ow_rd_data[15:0]), 32'(exp_q[0]));
                if (iw_rd_ready) begin
`ifdef PIPE_TRACE_TS_EN
                    ts_seen.push_back(ow_rd_data[EW-1 -: TS_W]);
`endif
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic arm(input int post);
        iw_arm  = 1'b1;
        iw_post = AW'(post);
        tick();
        iw_arm = 1'b0;
        exp_q.delete();
    endtask

    task automatic smp(input logic [15:0] v, input logic t);
        iw_valid = 1'b1;
        iw_ch    = v;
        iw_trig  = t;
        tick();
        iw_valid = 1'b0;
        iw_trig  = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int n = 0;
        while (ow_state !== st && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(ow_state), 32'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_state", 32'(ow_state), 32'd0);
        check("rst_rd_valid", 32'(ow_rd_valid), 32'd0);
        check("rst_rd_data", 32'(ow_rd_data), 32'd0);
        check("rst_fill", 32'(ow_fill), 32'd0);
        check("rst_trig_idx", 32'(ow_trig_idx), 32'd0);
        iw_rst_n = 1'b1;
        tick();

        // Basic capture, trigger mid-stream, two post samples.
        arm(2);
        check("t1_armed", 32'(ow_state), 32'd1);
        check("t1_fill0", 32'(ow_fill), 32'd0);
        smp(16'h0101, 1'b0);
        smp(16'h0202, 1'b0);
        smp(16'h0303, 1'b1);
        check("t1_post", 32'(ow_state), 32'd2);
        check("t1_fill3", 32'(ow_fill), 32'd3);
        smp(16'h0404, 1'b0);
        smp(16'h0505, 1'b0);
        check("t1_done", 32'(ow_state), 32'd3);
        check("t1_fill", 32'(ow_fill), 32'd5);
        check("t1_trig_idx", 32'(ow_trig_idx), 32'd2);
        check("t1_rd_valid_late", 32'(ow_rd_valid), 32'd0);
        exp_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        wait_state(2'd0, 40, "t1_idle");
        check("t1_drained", 32'(exp_q.size()), 32'd0);
        check("t1_rd_valid_off", 32'(ow_rd_valid), 32'd0);

        // Ring wrap: 12 samples into 8 slots.
        arm(1);
        for (int i = 0; i < 12; i++) smp(16'(i), i == 10);
        check("t2_done", 32'(ow_state), 32'd3);
        check("t2_fill", 32'(ow_fill), 32'd8);
        check("t2_trig_idx", 32'(ow_trig_idx), 32'd6);
        for (int i = 4; i < 12; i++) exp_q.push_back(16'(i));
        wait_state(2'd0, 40, "t2_idle");
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Zero post count: trigger sample alone.
        arm(0);
        smp(16'h0077, 1'b1);
        check("t3_done", 32'(ow_state), 32'd3);
        check("t3_fill", 32'(ow_fill), 32'd1);
        check("t3_trig_idx", 32'(ow_trig_idx), 32'd0);
        exp_q.push_back(16'h0077);
        wait_state(2'd0, 20, "t3_idle");
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Ignored triggers (arm cycle, no valid, in POST) and readout back-pressure.
        iw_rd_ready = 1'b0;
        iw_arm = 1'b1; iw_post = 3'd1; iw_valid = 1'b1; iw_trig = 1'b1; iw_ch = 16'h0999;
        tick();
        iw_arm = 1'b0; iw_valid = 1'b0; iw_trig = 1'b0;
        exp_q.delete();
        check("t4_arm_trig_state", 32'(ow_state), 32'd1);
        check("t4_arm_trig_fill", 32'(ow_fill), 32'd0);
        iw_trig = 1'b1;
        tick();
        iw_trig = 1'b0;
        check("t4_novalid_trig", 32'(ow_state), 32'd1);
        smp(16'h0A0A, 1'b1);
        check("t4_post", 32'(ow_state), 32'd2);
        smp(16'h0B0B, 1'b1);
        check("t4_done", 32'(ow_state), 32'd3);
        check("t4_fill", 32'(ow_fill), 32'd2);
        check("t4_trig_idx", 32'(ow_trig_idx), 32'd0);
        exp_q = '{16'h0A0A, 16'h0B0B};
        repeat (5) tick();
        check("t4_stall_state", 32'(ow_state), 32'd3);
        check("t4_stall_valid", 32'(ow_rd_valid), 32'd1);
        check("t4_stall_pending", 32'(exp_q.size()), 32'd2);
        iw_rd_ready = 1'b1;
        wait_state(2'd0, 20, "t4_idle");
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during POST discards the trace.
        arm(3);
        smp(16'h1111, 1'b1);
        check("t5_post", 32'(ow_state), 32'd2);
        #2 iw_rst_n = 1'b0;
        #1;
        check("t5_rst_state", 32'(ow_state), 32'd0);
        check("t5_rst_fill", 32'(ow_fill), 32'd0);
        check("t5_rst_valid", 32'(ow_rd_valid), 32'd0);
        tick();
        iw_rst_n = 1'b1;
        tick();
        smp(16'h2222, 1'b1);
        check("t5_no_arm_state", 32'(ow_state), 32'd0);
        check("t5_no_arm_fill", 32'(ow_fill), 32'd0);

        // Re-arm in the middle of a stalled readout.
        iw_rd_ready = 1'b0;
        arm(1);
        smp(16'h3131, 1'b0);
        smp(16'h3232, 1'b1);
        smp(16'h3333, 1'b0);
        exp_q = '{16'h3131, 16'h3232, 16'h3333};
        tick();
        tick();
        check("t6_reading", 32'(ow_rd_valid), 32'd1);
        arm(2);
        check("t6_abort_state", 32'(ow_state), 32'd1);
        check("t6_abort_fill", 32'(ow_fill), 32'd0);
        check("t6_abort_valid", 32'(ow_rd_valid), 32'd0);
        iw_rd_ready = 1'b1;
        smp(16'h4444, 1'b1);
        smp(16'h4545, 1'b0);
        smp(16'h4646, 1'b0);
        check("t6_done", 32'(ow_state), 32'd3);
        check("t6_fill", 32'(ow_fill), 32'd3);
        exp_q = '{16'h4444, 16'h4545, 16'h4646};
        wait_state(2'd0, 20, "t6_idle");
        check("t6_drained", 32'(exp_q.size()), 32'd0);

`ifdef PIPE_TRACE_TS_EN
        // Samples 20 cycles apart carry timestamps 20 mod 16 apart.
        arm(0);
        ts_seen.delete();
        smp(16'h0001, 1'b0);
        repeat (19) tick();
        smp(16'h0002, 1'b1);
        exp_q = '{16'h0001, 16'h0002};
        wait_state(2'd0, 20, "ts_idle");
        check("ts_count", 32'(ts_seen.size()), 32'd2);
        if (ts_seen.size() == 2) begin
            logic [TS_W-1:0] d;
            d = ts_seen[1] - ts_seen[0];
            check("ts_delta", 32'(d), 32'd4);
        end
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_trace.md
PIPE_TRACE -- requirements
Module: pipe_trace

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of sampled channels (pipeline stages).
REQ-002 SHALL have parameter CH_W, default 24, width of each channel.
REQ-003 SHALL have parameter DEPTH, default 64, trace entries; power of two, minimum 4.
REQ-004 SHALL have parameter TS_W, default 16, timestamp width (used only with PIPE_TRACE_TS_EN).
REQ-005 SHALL have port iw_clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port iw_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port iw_ch, input, N_CH*CH_W, channel k at bits [k*CH_W +: CH_W].
REQ-008 SHALL have port iw_valid, input, 1, sample-enable qualifier.
REQ-009 SHALL have port iw_arm, input, 1, single-cycle arm/restart pulse.
REQ-010 SHALL have port iw_trig, input, 1, trigger condition.
REQ-011 SHALL have port iw_post, input, log2(DEPTH), post-trigger sample count, latched at arm.
REQ-012 SHALL have port iw_rd_ready, input, 1, readout consumer ready.
REQ-013 SHALL have port ow_rd_valid, output, 1, readout entry valid.
REQ-014 SHALL have port ow_rd_data, output, ENTRY_W, readout entry; ENTRY_W = N_CH*CH_W (+TS_W with timestamp).
REQ-015 SHALL have port ow_state, output, 2, FSM state encoding.
REQ-016 SHALL have port ow_trig_idx, output, log2(DEPTH), readout position of the trigger entry.
REQ-017 SHALL have port ow_fill, output, log2(DEPTH)+1, entries held.

Function
REQ-018 SHALL implement states IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-019 SHALL enter ARMED from any state on iw_arm; clear write pointer and fill; latch iw_post; abort any readout.
REQ-020 ARMED: SHALL write each iw_valid sample at the write pointer, wrap modulo DEPTH, saturate fill at DEPTH.
REQ-021 ARMED: iw_trig&iw_valid SHALL write the trigger sample, record its buffer slot, go to POST (post count 0: go straight to DONE).
REQ-022 iw_trig without iw_valid, in IDLE/POST/DONE, or in the iw_arm cycle SHALL be ignored.
REQ-023 POST: SHALL write exactly latched-post further valid samples, then enter DONE on the cycle after the last write.
REQ-024 DONE: SHALL read out ow_fill entries oldest first; oldest slot = write pointer when fill=DEPTH, else slot 0.
REQ-025 ow_rd_valid SHALL rise one cycle after entering DONE; an entry transfers when ow_rd_valid&iw_rd_ready; ow_rd_data SHALL hold stable while ow_rd_valid&!iw_rd_ready.
REQ-026 After the last transfer SHALL drop ow_rd_valid in the same edge and return to IDLE.
REQ-027 ow_trig_idx SHALL equal (trigger slot - oldest slot) modulo DEPTH, valid in DONE.
REQ-028 No writes SHALL occur in IDLE or DONE.

Reset
REQ-029 Reset SHALL force IDLE, ow_rd_valid=0, ow_rd_data=0, ow_trig_idx=0, ow_fill=0, pointers and timestamp 0; buffer contents need not be cleared.
REQ-030 Reset mid-capture or mid-readout SHALL discard the trace; first post-reset action requires iw_arm.

Configuration
REQ-031 With PIPE_TRACE_TS_EN defined: free-running TS_W-bit cycle counter wrapping at 2^TS_W; each entry stores counter value in top TS_W bits of ow_rd_data.
REQ-032 Without PIPE_TRACE_TS_EN: no counter; ENTRY_W = N_CH*CH_W.

Structure
REQ-033 State encodings and ENTRY_W helper SHALL live in shared package pipe_trace_pkg.
REQ-034 Storage SHALL be one sub-module trace_ram (simple dual-port, registered read, one write port, one read port).

Verification (N_CH=2, CH_W=8, DEPTH=8)
REQ-035 Arm post=2; valid samples 0x0101..0x0505, trig on 0x0303 -> DONE; readout 0x0101..0x0505; trig_idx=2; fill=5.
REQ-036 Arm post=1; 12 valid samples 0x00..0x0B, trig on 0x0A -> fill=8; readout 0x04..0x0B (wrap); trig_idx=6.
REQ-037 Arm post=0, trig on first valid sample 0x77 -> DONE next cycle; one entry 0x77; trig_idx=0.
REQ-038 In DONE hold iw_rd_ready=0 five cycles, then 1 -> data stable; each entry exactly once; IDLE after last.
REQ-039 Assert iw_rst_n=0 in POST, and separately iw_arm mid-readout -> IDLE/ARMED, fill=0, ow_rd_valid=0 immediately.
REQ-040 With PIPE_TRACE_TS_EN, TS_W=4, samples 20 cycles apart -> stored timestamps differ by 20 mod 16 = 4.
